// File: rtl/sim_end_ctrl.sv
// sim_end_ctrl: end-of-simulation sequencer that collects done/error/timeout events,
// waits a drain window, then holds endend with a final status; also emits a run heartbeat.
module sim_end_ctrl #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned MAX_CYCLES   = 1000000,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned HB_PERIOD    = 1024,
    parameter int unsigned CODE_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done_valid,
    input  logic [CODE_W-1:0] done_code,
    output logic              done_ready,
    input  logic              error,
    output logic              endend,
    output logic [1:0]        status,
    output logic [CODE_W-1:0] final_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              heartbeat
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] ST_END = 2'd3;
    localparam int DR_W = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
    localparam int HB_W = HB_PERIOD > 1 ? $clog2(HB_PERIOD) : 1;
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);
    localparam logic [63:0]     TO_LAST = 64'(MAX_CYCLES) - 64'd1;
    localparam bit              TO_EN   = MAX_CYCLES != 0;
    localparam bit              HB_EN   = HB_PERIOD != 0;
    logic [1:0]      state, state_nxt;
    logic [DR_W-1:0] drain_cnt;
    logic [HB_W-1:0] hb_cnt;
    logic            in_run, err_ev, done_ev, to_ev, end_ev, hb_wrap;
    assign in_run  = state == RUN;
    assign err_ev  = in_run & error;
    assign done_ev = in_run & done_valid & done_ready;
    // compared at 64 bits so MAX_CYCLES beyond the counter range simply never fires
    assign to_ev   = in_run & TO_EN & (64'(cycle_count) == TO_LAST);
    assign end_ev  = err_ev | done_ev | to_ev;
    assign hb_wrap = in_run & HB_EN & (hb_cnt == HB_LAST);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = end_ev ? DRAIN : RUN;
            DRAIN:   state_nxt = (drain_cnt == DR_LAST) ? ST_END : DRAIN;
            default: state_nxt = ST_END;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done_ready  <= 1'b0;
            endend      <= 1'b0;
            status      <= 2'd0;
            final_code  <= '0;
            cycle_count <= '0;
            drain_cnt   <= '0;
            hb_cnt      <= '0;
            heartbeat   <= 1'b0;
        end else begin
            state       <= state_nxt;
            done_ready  <= state_nxt == RUN;
            endend      <= endend | (state_nxt == ST_END);
            drain_cnt   <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            cycle_count <= (in_run && cycle_count != '1) ? cycle_count + 1'b1 : cycle_count;
            hb_cnt      <= (!in_run || hb_wrap || !HB_EN) ? '0 : hb_cnt + 1'b1;
            heartbeat   <= hb_wrap;
            if (end_ev) begin
                status     <= err_ev ? 2'd2 : done_ev ? ((done_code == '0) ? 2'd1 : 2'd2) : 2'd3;
                final_code <= err_ev ? '1 : done_ev ? done_code : '0;
            end
        end
    end
endmodule

// File: tb/tb_sim_end_ctrl.sv
// tb_sim_end_ctrl: randomized and directed checks of two sim_end_ctrl configurations
// against an event-timestamp reference model.
module tb_sim_end_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0, done_valid = 1'b0, error = 1'b0;
    logic [7:0] done_code = 8'h00;
    logic rdy_a, end_a, hb_a, rdy_b, end_b, hb_b;
    logic [1:0] st_a, st_b;
    logic [7:0] fc_a, fc_b;
    logic [31:0] cc_a;
    logic [3:0] cc_b;
    int n_tests = 0, n_fail = 0, hb_seen = 0;
    longint p_max[2]   = '{50, 0};
    longint p_drain[2] = '{4, 1};
    longint p_hb[2]    = '{8, 0};
    longint p_sat[2]   = '{64'hFFFF_FFFF, 15};
    bit m_started[2], m_hb[2];
    longint m_runs[2], m_edge[2], m_ev[2];
    logic [1:0] m_st[2];
    logic [7:0] m_code[2];

    always #5 clk = ~clk;

    sim_end_ctrl #(.CNT_W(32), .MAX_CYCLES(50), .DRAIN_CYCLES(4), .HB_PERIOD(8), .CODE_W(8)) u_a (
        .clk(clk), .reset(reset), .start(start), .done_valid(done_valid), .done_code(done_code),
        .done_ready(rdy_a), .error(error), .endend(end_a), .status(st_a), .final_code(fc_a),
        .cycle_count(cc_a), .heartbeat(hb_a));

    sim_end_ctrl #(.CNT_W(4), .MAX_CYCLES(0), .DRAIN_CYCLES(1), .HB_PERIOD(0), .CODE_W(8)) u_b (
        .clk(clk), .reset(reset), .start(start), .done_valid(done_valid), .done_code(done_code),
        .done_ready(rdy_b), .error(error), .endend(end_b), .status(st_b), .final_code(fc_b),
        .cycle_count(cc_b), .heartbeat(hb_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_started[i] = 0; m_hb[i] = 0; m_runs[i] = 0; m_edge[i] = 0; m_ev[i] = -1;
            m_st[i] = 2'd0; m_code[i] = 8'h00;
        end
    endtask

    // run ends at the first event edge; endend is a pure function of that timestamp
    task automatic model_edge(input logic st, input logic dv, input logic [7:0] dc, input logic er);
        longint cc;
        for (int i = 0; i < 2; i++) begin
            m_hb[i] = 0;
            m_edge[i]++;
            if (!m_started[i]) m_started[i] = st;
            else if (m_ev[i] < 0) begin
                cc = (m_runs[i] > p_sat[i]) ? p_sat[i] : m_runs[i];
                m_runs[i]++;
                if (p_hb[i] != 0 && m_runs[i] % p_hb[i] == 0) m_hb[i] = 1;
                if (er) begin
                    m_st[i] = 2'd2; m_code[i] = 8'hFF; m_ev[i] = m_edge[i];
                end else if (dv) begin
                    m_st[i] = (dc == 0) ? 2'd1 : 2'd2; m_code[i] = dc; m_ev[i] = m_edge[i];
                end else if (p_max[i] != 0 && cc == p_max[i] - 1) begin
                    m_st[i] = 2'd3; m_code[i] = 8'h00; m_ev[i] = m_edge[i];
                end
            end
        end
    endtask

    task automatic check_one(input int i, input logic e, input logic [1:0] s, input logic [7:0] fc,
                             input logic [63:0] cc, input logic r, input logic h);
        longint sat_runs;
        sat_runs = (m_runs[i] > p_sat[i]) ? p_sat[i] : m_runs[i];
        check($sformatf("u%0d.endend", i), 64'(e), 64'(m_ev[i] >= 0 && m_edge[i] >= m_ev[i] + p_drain[i]));
        check($sformatf("u%0d.status", i), 64'(s), 64'(m_st[i]));
        check($sformatf("u%0d.final_code", i), 64'(fc), 64'(m_code[i]));
        check($sformatf("u%0d.cycle_count", i), cc, 64'(sat_runs));
        check($sformatf("u%0d.done_ready", i), 64'(r), 64'(m_started[i] && m_ev[i] < 0));
        check($sformatf("u%0d.heartbeat", i), 64'(h), 64'(m_hb[i]));
    endtask

    task automatic check_all();
        check_one(0, end_a, st_a, fc_a, 64'(cc_a), rdy_a, hb_a);
        check_one(1, end_b, st_b, fc_b, 64'(cc_b), rdy_b, hb_b);
    endtask

    task automatic step(input logic st, input logic dv, input logic [7:0] dc, input logic er);
        @(negedge clk);
        start = st; done_valid = dv; done_code = dc; error = er;
        @(posedge clk);
        model_edge(st, dv, dc, er);
        #1;
        check_all();
        if (hb_a) hb_seen++;
    endtask

    // asserted between edges so the outputs must clear without any clock
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; done_valid = 1'b0; error = 1'b0; done_code = 8'h00;
        #1;
        model_reset();
        check_all();
        #2 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 check_all();
        do_reset();
        step(1, 0, 8'h00, 0);
        repeat (4) step(1, 0, 8'h00, 0);
        step(1, 1, 8'h00, 0);
        repeat (6) step(1, 1, 8'h3C, 0);
        check("s1.cycle_count", 64'(cc_a), 64'd5);
        check("s1.status", 64'(st_a), 64'd1);
        check("s1.endend", 64'(end_a), 64'd1);

        do_reset();
        step(1, 0, 8'h00, 0);
        repeat (2) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h3C, 0);
        repeat (5) step(0, 1, 8'h55, 1);
        check("s2.status", 64'(st_a), 64'd2);
        check("s2.final_code", 64'(fc_a), 64'h3C);

        do_reset();
        step(1, 0, 8'h00, 0);
        repeat (3) step(1, 0, 8'h00, 0);
        step(1, 1, 8'h11, 1);
        repeat (5) step(1, 0, 8'h00, 0);
        check("s3.final_code", 64'(fc_a), 64'hFF);
        check("s3.status", 64'(st_a), 64'd2);

        do_reset();
        step(1, 0, 8'h00, 0);
        hb_seen = 0;
        repeat (60) step(0, 0, 8'h00, 0);
        check("s4.heartbeats", 64'(hb_seen), 64'd6);
        check("s4.status", 64'(st_a), 64'd3);
        check("s4.endend", 64'(end_a), 64'd1);
        check("s4.cycle_count", 64'(cc_a), 64'd50);
        check("s4.sat_count", 64'(cc_b), 64'hF);
        check("s4.no_timeout", 64'(end_b), 64'd0);

        do_reset();
        step(1, 0, 8'h00, 0);
        repeat (3) step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 1);
        repeat (2) step(0, 0, 8'h00, 0);
        do_reset();
        step(1, 0, 8'h00, 0);
        repeat (3) step(0, 0, 8'h00, 0);
        step(0, 1, 8'h00, 0);
        repeat (6) step(0, 0, 8'h00, 0);
        check("s5.status", 64'(st_a), 64'd1);
        check("s5.endend", 64'(end_a), 64'd1);

        for (int it = 0; it < 40; it++) begin
            do_reset();
            for (int c = 0; c < 70; c++)
                step($urandom_range(3) == 0, $urandom_range(11) == 0,
                     $urandom_range(1) == 1 ? 8'($urandom) : 8'h00, $urandom_range(39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
